motor_bridge_guard: RTL

Registered H-bridge protection stage sitting directly downstream of the line-following FSM and upstream of the motor driver pins. It takes the FSM's PWM-gated direction commands for motors A and B (`_d` = forward, `_i` = reverse) and enforces three rules:
- No shoot-through.
- A programmable dead-time on every direction reversal.
- A clean all-off state on disable or illegal commands.

Same-direction PWM gaps pass through with no added delay.

---
 rtl/motor_bridge_guard.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/motor_bridge_guard.sv
// H-bridge protection stage: shoot-through blocking, reversal dead-time
// and sticky illegal-command faults for two independent motor channels.

module motor_bridge_chan #(
  parameter int DEAD_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr_fault,
  input  logic cmd_d,
  input  logic cmd_i,
  output logic drv_d,
  output logic drv_i,
  output logic dead,
  output logic fault
);

  localparam int CW = $clog2(DEAD_CYCLES + 1);
  localparam logic [CW-1:0] DC_V = CW'(DEAD_CYCLES);

  typedef enum logic [1:0] {
    ST_OFF,
    ST_FWD,
    ST_REV
  } st_e;

  typedef enum logic [1:0] {
    DIR_NONE,
    DIR_FWD,
    DIR_REV
  } dir_e;

  st_e           st_q, st_d;
  dir_e          last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          fault_q, fault_d;

  logic illegal;
  logic cnt_full;

  assign illegal  = cmd_d & cmd_i;
  assign cnt_full = (cnt_q == DC_V);

  always_comb begin
    st_d    = ST_OFF;
    last_d  = last_q;
    cnt_d   = cnt_q;
    fault_d = fault_q;

    if (illegal) begin
      st_d = ST_OFF;
    end else if (!en) begin
      st_d = ST_OFF;
    end else if (cmd_d) begin
      case (st_q)
        ST_FWD:  st_d = ST_FWD;
        ST_OFF:  st_d = (last_q != DIR_REV || cnt_full) ? ST_FWD : ST_OFF;
        default: st_d = ST_OFF;
      endcase
    end else if (cmd_i) begin
      case (st_q)
        ST_REV:  st_d = ST_REV;
        ST_OFF:  st_d = (last_q != DIR_FWD || cnt_full) ? ST_REV : ST_OFF;
        default: st_d = ST_OFF;
      endcase
    end else begin
      st_d = ST_OFF;
    end

    // A new illegal command wins over a simultaneous clear.
    if (illegal) begin
      fault_d = 1'b1;
    end else if (clr_fault) begin
      fault_d = 1'b0;
    end

    if (st_d == ST_FWD) begin
      last_d = DIR_FWD;
    end else if (st_d == ST_REV) begin
      last_d = DIR_REV;
    end

    if (st_d != ST_OFF) begin
      cnt_d = '0;
    end else if (st_q != ST_OFF) begin
      cnt_d = CW'(1);
    end else if (!cnt_full) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Reset preloads the counter so the first start after reset is immediate.
  always_ff @(posedge clk) begin
    if (reset) begin
      st_q    <= ST_OFF;
      last_q  <= DIR_NONE;
      cnt_q   <= DC_V;
      fault_q <= 1'b0;
    end else begin
      st_q    <= st_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end

  assign drv_d = (st_q == ST_FWD);
  assign drv_i = (st_q == ST_REV);
  assign fault = fault_q;

  assign dead = (st_q == ST_OFF) && !cnt_full && !illegal &&
                ((cmd_d && last_q == DIR_REV) ||
                 (cmd_i && last_q == DIR_FWD));

endmodule

module motor_bridge_guard #(
  parameter int DEAD_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr_fault,
  input  logic cmd_a_d,
  input  logic cmd_a_i,
  input  logic cmd_b_d,
  input  logic cmd_b_i,
  output logic motorA_d,
  output logic motorA_i,
  output logic motorB_d,
  output logic motorB_i,
  output logic dead_a,
  output logic dead_b,
  output logic fault_a,
  output logic fault_b
);

  motor_bridge_chan #(
    .DEAD_CYCLES(DEAD_CYCLES)
  ) u_chan_a (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .clr_fault(clr_fault),
    .cmd_d    (cmd_a_d),
    .cmd_i    (cmd_a_i),
    .drv_d    (motorA_d),
    .drv_i    (motorA_i),
    .dead     (dead_a),
    .fault    (fault_a)
  );

  motor_bridge_chan #(
    .DEAD_CYCLES(DEAD_CYCLES)
  ) u_chan_b (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .clr_fault(clr_fault),
    .cmd_d    (cmd_b_d),
    .cmd_i    (cmd_b_i),
    .drv_d    (motorB_d),
    .drv_i    (motorB_i),
    .dead     (dead_b),
    .fault    (fault_b)
  );

endmodule
